// File: rtl/csa_pkg.sv
// Shared types and constants for the carry-select arithmetic slice.
package csa_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int unsigned DIV_STEPS = 8;
   localparam int unsigned CNT_W     = 3;

   // True on the step that produces the final quotient bit.
   function automatic logic is_last_step(input logic [CNT_W-1:0] cnt);
      return cnt == CNT_W'(DIV_STEPS - 1);
   endfunction

endpackage

// File: rtl/adder_4.sv
// 4-bit ripple adder: the building block of the carry-select halves.
module adder_4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);

   // Plain addition with carry in and carry out.
   always_comb begin
      {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'd0, cin_i};
   end

endmodule

// File: rtl/csa_sub_8.sv
// 8-bit carry-select subtractor: a - b computed as a + ~b + 1.
// The upper nibble is precomputed for both carries and selected by the
// lower nibble's carry-out; borrow is the inverted final carry.
module csa_sub_8 (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic [7:0] diff_o,
   output logic       borrow_o
);

   logic [7:0] b_n;
   logic [3:0] sum_lo;
   logic       c_lo;
   logic [3:0] sum_hi0;
   logic [3:0] sum_hi1;
   logic       c_hi0;
   logic       c_hi1;
   logic       c_out;

   assign b_n = ~b_i;

   adder_4 u_lo (
      .a_i    (a_i[3:0]),
      .b_i    (b_n[3:0]),
      .cin_i  (1'b1),
      .sum_o  (sum_lo),
      .cout_o (c_lo)
   );

   adder_4 u_hi0 (
      .a_i    (a_i[7:4]),
      .b_i    (b_n[7:4]),
      .cin_i  (1'b0),
      .sum_o  (sum_hi0),
      .cout_o (c_hi0)
   );

   adder_4 u_hi1 (
      .a_i    (a_i[7:4]),
      .b_i    (b_n[7:4]),
      .cin_i  (1'b1),
      .sum_o  (sum_hi1),
      .cout_o (c_hi1)
   );

   // Select the upper half on the lower carry-out.
   always_comb begin
      diff_o[3:0] = sum_lo;
      if (c_lo) begin
         diff_o[7:4] = sum_hi1;
         c_out       = c_hi1;
      end else begin
         diff_o[7:4] = sum_hi0;
         c_out       = c_hi0;
      end
      borrow_o = ~c_out;
   end

endmodule

// File: rtl/csa_div_8.sv
// Sequential 8-bit unsigned restoring divider, one quotient bit per cycle,
// with valid/ready handshakes on both the operand and the result side.
module csa_div_8
   import csa_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter logic [7:0]  DBZ_QUOT = 8'hFF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             dbz
);

   if (WIDTH != 8) begin : g_bad_width
      $error("csa_div_8: only WIDTH=8 is supported");
   end

   div_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [7:0]       rem_q;     // partial remainder
   logic [7:0]       shreg_q;   // dividend bits shifting out, quotient bits shifting in
   logic [7:0]       dvsr_q;
   logic [7:0]       quot_q;    // result registers, only written on entry to DONE
   logic [7:0]       remo_q;
   logic             dbz_q;

   logic [8:0]       sh;
   logic [7:0]       diff;
   logic             borrow;
   logic             ge;
   logic [7:0]       rem_d;
   logic [7:0]       shreg_d;
   logic             accept;

   assign accept = in_valid && (state_q == IDLE);

   // One restoring step: trial-subtract the divisor from the shifted remainder.
   always_comb begin
      sh      = {rem_q, shreg_q[7]};
      ge      = sh[8] | ~borrow;
      rem_d   = ge ? diff : sh[7:0];
      shreg_d = {shreg_q[6:0], ge};
   end

   csa_sub_8 u_sub (
      .a_i      (sh[7:0]),
      .b_i      (dvsr_q),
      .diff_o   (diff),
      .borrow_o (borrow)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = (divisor == '0) ? DONE : CALC;
         CALC: if (is_last_step(cnt_q)) state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);

   // Operand capture, iteration and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         rem_q   <= '0;
         shreg_q <= '0;
         dvsr_q  <= '0;
         quot_q  <= '0;
         remo_q  <= '0;
         dbz_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (divisor == '0) begin
                     quot_q <= DBZ_QUOT;
                     remo_q <= dividend;
                     dbz_q  <= 1'b1;
                  end else begin
                     dvsr_q  <= divisor;
                     shreg_q <= dividend;
                     rem_q   <= '0;
                     cnt_q   <= '0;
                     dbz_q   <= 1'b0;
                  end
               end
            end
            CALC: begin
               rem_q   <= rem_d;
               shreg_q <= shreg_d;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (is_last_step(cnt_q)) begin
                  quot_q <= shreg_d;
                  remo_q <= rem_d;
               end
            end
            default: ;
         endcase
      end
   end

   assign quotient  = quot_q;
   assign remainder = remo_q;
   assign dbz       = dbz_q;

endmodule
